// File: rtl/qspi_sim_pkg.sv
// Shared types and default sizing for the QSPI simulation helpers.
// Used by the read-data latency line and its bench.
package qspi_sim_pkg;

    typedef enum logic [1:0] {
        LAT_CAPTURE,
        LAT_RUN,
        LAT_FLUSH
    } lat_state_e;

    localparam int unsigned QSPI_LANE_W  = 4;
    localparam int unsigned QSPI_MAX_LAT = 5;

endpackage

// File: rtl/qspi_delay_stage.sv
// One stage of the latency line: a W-bit register with shift enable
// and a synchronous clear that takes priority over the shift.
module qspi_delay_stage #(
    parameter int unsigned    W       = 5,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= CLR_VAL;
        end else if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/qspi_latency_line.sv
// QSPI read-data latency emulator: delays lane data by a run-time selected
// number of cycles, with a per-stage valid bit, flush on reload and clamp.
module qspi_latency_line
    import qspi_sim_pkg::*;
#(
    parameter int unsigned          DATA_W     = QSPI_LANE_W,
    parameter int unsigned          MAX_LAT    = QSPI_MAX_LAT,
    parameter int unsigned          LAT_W      = 3,
    parameter logic [DATA_W-1:0]    IDLE_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LAT_W-1:0]  cfg_latency,
    input  logic              cfg_reload,
    input  logic              cs_active,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [LAT_W-1:0]  cur_latency,
    output logic              cfg_error
);

    localparam int unsigned       SW        = DATA_W + 1;
    localparam logic [SW-1:0]     STAGE_CLR = {1'b0, IDLE_VALUE};
    localparam logic [LAT_W-1:0]  MAX_LAT_L = LAT_W'(MAX_LAT);

    lat_state_e        r_state;
    lat_state_e        w_state_next;
    logic              w_load;
    logic [LAT_W-1:0]  r_cur_latency;
    logic [LAT_W-1:0]  r_fill_cnt;
    logic              r_cfg_error;
    logic              w_lat_over;
    logic [LAT_W-1:0]  w_lat_clamped;
    logic [SW-1:0]     w_stage_d [MAX_LAT];
    logic [SW-1:0]     w_stage_q [MAX_LAT];
    logic [SW-1:0]     w_tap;
    logic [DATA_W-1:0] w_data_out;
    logic              w_data_valid;
    logic              w_shift;
    logic              w_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LAT_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            LAT_CAPTURE: begin
                w_load       = 1'b1;
                w_state_next = LAT_RUN;
            end
            LAT_RUN: begin
                if (cfg_reload) begin
                    w_state_next = LAT_FLUSH;
                end
            end
            LAT_FLUSH: begin
                w_load       = 1'b1;
                w_state_next = LAT_RUN;
            end
            default: w_state_next = LAT_CAPTURE;
        endcase
    end

    assign w_lat_over    = (cfg_latency > MAX_LAT_L);
    assign w_lat_clamped = w_lat_over ? MAX_LAT_L : cfg_latency;
    assign w_shift       = (r_state == LAT_RUN);
    assign w_clear       = (r_state == LAT_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_latency <= '0;
            r_cfg_error   <= 1'b0;
            r_fill_cnt    <= '0;
        end else begin
            if (w_load) begin
                r_cur_latency <= w_lat_clamped;
                if (w_lat_over) begin
                    r_cfg_error <= 1'b1;
                end
            end
            if (w_clear) begin
                r_fill_cnt <= '0;
            end else if (w_shift && (r_fill_cnt < r_cur_latency)) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
        end
    end

    // Each stage carries {valid, data} so the valid bit travels with its beat.
    for (genvar g = 0; g < MAX_LAT; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_stage_d[g] = {cs_active, data_in};
        end else begin : g_body
            assign w_stage_d[g] = w_stage_q[g-1];
        end
        qspi_delay_stage #(
            .W       (SW),
            .CLR_VAL (STAGE_CLR)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_shift),
            .i_clr (w_clear),
            .i_d   (w_stage_d[g]),
            .o_q   (w_stage_q[g])
        );
    end

    always_comb begin
        w_tap = STAGE_CLR;
        for (int unsigned i = 0; i < MAX_LAT; i++) begin
            if (r_cur_latency == LAT_W'(i + 1)) begin
                w_tap = w_stage_q[i];
            end
        end
        w_data_valid = 1'b0;
        w_data_out   = IDLE_VALUE;
        if (r_state == LAT_RUN) begin
            if (r_cur_latency == '0) begin
                w_data_valid = cs_active;
            end else begin
                // Beats are trusted only once the line has filled up to the tap.
                w_data_valid = w_tap[DATA_W] && (r_fill_cnt == r_cur_latency);
            end
        end
        if (w_data_valid) begin
            w_data_out = (r_cur_latency == '0) ? data_in : w_tap[DATA_W-1:0];
        end
    end

    assign data_out    = w_data_out;
    assign data_valid  = w_data_valid;
    assign cur_latency = r_cur_latency;
    assign cfg_error   = r_cfg_error;

endmodule

// File: tb/tb_qspi_latency_line.sv
// Directed bench for qspi_latency_line with hand-computed expectations.
module tb_qspi_latency_line;

    logic       clk;
    logic       rst_n;
    logic [2:0] cfg_latency;
    logic       cfg_reload;
    logic       cs_active;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic [2:0] cur_latency;
    logic       cfg_error;

    int checks = 0;
    int errors = 0;

    qspi_latency_line #(
        .DATA_W     (4),
        .MAX_LAT    (5),
        .LAT_W      (3),
        .IDLE_VALUE (4'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_latency (cfg_latency),
        .cfg_reload  (cfg_reload),
        .cs_active   (cs_active),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .cur_latency (cur_latency),
        .cfg_error   (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Holds reset with the given latency, releases it, returns 1 ns after the CAPTURE edge.
    task automatic reset_to(input logic [2:0] lat);
        rst_n       = 1'b0;
        cfg_latency = lat;
        cfg_reload  = 1'b0;
        cs_active   = 1'b0;
        data_in     = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        cfg_latency = 3'd0;
        cfg_reload  = 1'b0;
        cs_active   = 1'b1;
        data_in     = 4'hA;
        repeat (2) @(negedge clk);
        checks++;
        if (data_out !== 4'h0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: data_out=%h valid=%b, want 0/0", data_out, data_valid);
        end
        checks++;
        if (cur_latency !== 3'd0 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg: cur_latency=%0d cfg_error=%b, want 0/0", cur_latency, cfg_error);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 4'hA || data_valid !== 1'b1 || cur_latency !== 3'd0) begin
            errors++;
            $display("FAIL bypass_A: data_out=%h valid=%b lat=%0d, want A/1/0", data_out, data_valid, cur_latency);
        end
        data_in = 4'h5;
        #1;
        checks++;
        if (data_out !== 4'h5 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass_5: data_out=%h valid=%b, want 5/1", data_out, data_valid);
        end
        cs_active = 1'b0;
        #1;
        checks++;
        if (data_out !== 4'h0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_cs_low: data_out=%h valid=%b, want 0/0", data_out, data_valid);
        end
    endtask

    task automatic test_latency3();
        logic       exp_v;
        logic [3:0] exp_d;
        reset_to(3'd3);
        checks++;
        if (cur_latency !== 3'd3 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL lat3_cfg: cur_latency=%0d cfg_error=%b, want 3/0", cur_latency, cfg_error);
        end
        cs_active = 1'b1;
        data_in   = 4'd1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k >= 3);
            exp_d = exp_v ? 4'(k - 2) : 4'h0;
            checks++;
            if (data_valid !== exp_v || data_out !== exp_d) begin
                errors++;
                $display("FAIL lat3_ramp[%0d]: data_out=%h valid=%b, want %h/%b", k, data_out, data_valid, exp_d, exp_v);
            end
            data_in = 4'(k + 1);
        end
    endtask

    task automatic test_clamp();
        logic       exp_v;
        logic [3:0] exp_d;
        reset_to(3'd7);
        checks++;
        if (cur_latency !== 3'd5 || cfg_error !== 1'b1) begin
            errors++;
            $display("FAIL clamp_cfg: cur_latency=%0d cfg_error=%b, want 5/1", cur_latency, cfg_error);
        end
        cs_active   = 1'b1;
        data_in     = 4'd1;
        cfg_latency = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k >= 5);
            exp_d = exp_v ? 4'(k - 4) : 4'h0;
            checks++;
            if (data_valid !== exp_v || data_out !== exp_d) begin
                errors++;
                $display("FAIL clamp_ramp[%0d]: data_out=%h valid=%b, want %h/%b", k, data_out, data_valid, exp_d, exp_v);
            end
            data_in = 4'(k + 1);
        end
        checks++;
        if (cur_latency !== 3'd5) begin
            errors++;
            $display("FAIL clamp_no_reload: cur_latency=%0d, want 5", cur_latency);
        end
        cfg_latency = 3'd1;
        cfg_reload  = 1'b1;
        @(posedge clk);
        #1;
        cfg_reload = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cur_latency !== 3'd1 || cfg_error !== 1'b1) begin
            errors++;
            $display("FAIL clamp_sticky: cur_latency=%0d cfg_error=%b, want 1/1", cur_latency, cfg_error);
        end
    endtask

    task automatic test_burst();
        logic       cs_v [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] d_v  [9] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB};
        logic       exp_v;
        logic [3:0] exp_d;
        reset_to(3'd2);
        cs_active = cs_v[0];
        data_in   = d_v[0];
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k >= 2) && cs_v[k-2];
            exp_d = exp_v ? d_v[k-2] : 4'h0;
            checks++;
            if (data_valid !== exp_v || data_out !== exp_d) begin
                errors++;
                $display("FAIL burst[%0d]: data_out=%h valid=%b, want %h/%b", k, data_out, data_valid, exp_d, exp_v);
            end
            cs_active = cs_v[k];
            data_in   = d_v[k];
        end
    endtask

    task automatic test_reload();
        reset_to(3'd4);
        cs_active = 1'b1;
        data_in   = 4'd1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            data_in = 4'(k + 1);
        end
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'd2) begin
            errors++;
            $display("FAIL reload_pre: data_out=%h valid=%b, want 2/1", data_out, data_valid);
        end
        cfg_latency = 3'd1;
        cfg_reload  = 1'b1;
        @(posedge clk);
        #1;
        cfg_reload = 1'b0;
        data_in    = 4'h7;
        checks++;
        if (data_valid !== 1'b0 || data_out !== 4'h0) begin
            errors++;
            $display("FAIL reload_flush: data_out=%h valid=%b, want 0/0", data_out, data_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b0 || data_out !== 4'h0 || cur_latency !== 3'd1) begin
            errors++;
            $display("FAIL reload_run0: data_out=%h valid=%b lat=%0d, want 0/0/1", data_out, data_valid, cur_latency);
        end
        data_in = 4'hB;
        @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'hB) begin
            errors++;
            $display("FAIL reload_first: data_out=%h valid=%b, want B/1", data_out, data_valid);
        end
    endtask

    task automatic test_async_reset();
        reset_to(3'd3);
        cs_active = 1'b1;
        data_in   = 4'd1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            data_in = 4'(k + 1);
        end
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'd2) begin
            errors++;
            $display("FAIL areset_pre: data_out=%h valid=%b, want 2/1", data_out, data_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || data_out !== 4'h0 || cur_latency !== 3'd0) begin
            errors++;
            $display("FAIL areset_now: data_out=%h valid=%b lat=%0d, want 0/0/0", data_out, data_valid, cur_latency);
        end
        cfg_latency = 3'd2;
        cs_active   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cur_latency !== 3'd2 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_capture: cur_latency=%0d valid=%b, want 2/0", cur_latency, data_valid);
        end
        cs_active = 1'b1;
        data_in   = 4'h3;
        @(posedge clk);
        #1;
        data_in = 4'h4;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_lat2_early: valid=%b, want 0", data_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'h3) begin
            errors++;
            $display("FAIL areset_lat2: data_out=%h valid=%b, want 3/1", data_out, data_valid);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_latency = 3'd0;
        cfg_reload  = 1'b0;
        cs_active   = 1'b0;
        data_in     = 4'h0;
        test_reset();
        test_latency3();
        test_clamp();
        test_burst();
        test_reload();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_latency_line.md
Name: qspi_latency_line

Overview:
Parametrised, synthesizable QSPI read-data latency emulator. It generalises the bench-only data-delay shift register to N-bit lanes, a configurable maximum depth and run-time latency selection. It adds a per-stage valid pipeline, flush on reconfiguration, and latency capture at reset release. It sits between the simulated QSPI PMOD data output and the DUT's QSPI data input, in benches and in FPGA test harnesses.

Parameters:
DATA_W, 4, lane width in bits (4 for QSPI, 8 for octal).
MAX_LAT, 5, deepest supported delay in clk cycles (>=1).
LAT_W, 3, width of the latency config field; 2**LAT_W > MAX_LAT.
IDLE_VALUE, 0, value driven on data_out while no valid data is at the tap.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
cfg_latency  in  LAT_W  requested latency in cycles; sampled only in CAPTURE.
cfg_reload  in  1  single-cycle strobe: re-sample cfg_latency and flush.
cs_active  in  1  high while any QSPI select (flash, RAM A, RAM B) is asserted.
data_in  in  DATA_W  lane data from the memory model.
data_out  out  DATA_W  delayed lane data to the DUT.
data_valid  out  1  data_out carries data sampled while cs_active was high.
cur_latency  out  LAT_W  latency currently applied.
cfg_error  out  1  sticky; set if a captured cfg_latency exceeded MAX_LAT.

Behaviour:
- Reset (async, rst_n low): all stages = IDLE_VALUE, valid bits = 0, fill_cnt = 0, cur_latency = 0, cfg_error = 0, FSM = CAPTURE.
- Reset outputs: data_out = IDLE_VALUE, data_valid = 0.
- FSM states: CAPTURE, RUN, FLUSH.
  - CAPTURE: lasts one cycle, the first clk edge after rst_n rises. Latches cur_latency = min(cfg_latency, MAX_LAT). If cfg_latency > MAX_LAT, sets cfg_error. Goes to RUN.
  - RUN: the delay line shifts every cycle. cfg_reload = 1 -> FLUSH.
  - FLUSH: lasts one cycle. Clears all stages to IDLE_VALUE, clears valid bits and fill_cnt, re-latches cur_latency with the same clamp/error rule. Goes to RUN.
  - cfg_reload during CAPTURE or FLUSH is ignored.
- Delay line: MAX_LAT stages of DATA_W bits plus a parallel valid bit each.
  - stage[0] <= data_in and valid[0] <= cs_active; stage[i] <= stage[i-1].
  - Shifting happens in RUN only. The line holds during CAPTURE; FLUSH clears it.
- Latency tap, L = cur_latency:
  - L = 0: combinational bypass. data_out = data_in, data_valid = cs_active && state == RUN.
  - L >= 1: data_out = stage[L-1] (data_in exactly L cycles earlier); data_valid = valid[L-1] && fill_cnt == L.
  - When data_valid = 0, data_out = IDLE_VALUE.
- fill_cnt: counts RUN cycles since the last CAPTURE/FLUSH, saturating at L. Width covers MAX_LAT.
- cs_active deasserting mid-burst: no flush. The trailing L beats still emerge valid, then valid drops.
- cfg_latency changing while in RUN without cfg_reload has no effect.
- cfg_error clears only on reset.

Decomposition:
- Package qspi_sim_pkg holds:
  - the state enum: LAT_CAPTURE, LAT_RUN, LAT_FLUSH;
  - the default constants QSPI_LANE_W = 4 and QSPI_MAX_LAT = 5.
- One sub-module, qspi_delay_stage: one DATA_W+1-bit register with shift enable and synchronous clear, instantiated MAX_LAT times by a generate loop.
- The FSM, clamp, fill counter and tap mux stay in the top module.

Test Plan:
- Reset with cfg_latency = 0, data_in = 4'hA, cs_active = 1 -> after CAPTURE, data_out = 4'hA in the same cycle, data_valid = 1, cur_latency = 0.
- cfg_latency = 3; after CAPTURE drive the ramp 1,2,3,4… with cs_active = 1 -> data_valid rises exactly 3 cycles later with data_out = 1, then 2,3,4 on successive cycles.
- cfg_latency = 7 with MAX_LAT = 5 -> cur_latency = 5, cfg_error = 1, first valid beat 5 cycles after the ramp starts.
- Latency 2, cs_active high for 4 beats (9,8,7,6) then low -> data_out = 9,8,7,6 with data_valid = 1, then IDLE_VALUE with data_valid = 0.
- Latency 4 mid-stream: change cfg_latency to 1 and pulse cfg_reload:
  - the FLUSH cycle drops data_valid and discards in-flight beats;
  - the next data_in beat appears 1 cycle after the return to RUN;
  - cur_latency = 1.
- Assert rst_n low mid-burst at latency 3 -> data_out = IDLE_VALUE and data_valid = 0 immediately, without waiting for a clk edge. After release, the new cfg_latency = 2 is captured and applied.
